// File: rtl/sysfeed.sv
// Operand feeder for a 4x4 systolic multiply: holds matrices A and B and
// emits them as skewed left/top edge streams, one 12-cycle pass per start.
module sysfeed (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [1:0]   in_row,
    input  logic [127:0] in_data,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         arr_rst,
    output logic [31:0]  l1,
    output logic [31:0]  l2,
    output logic [31:0]  l3,
    output logic [31:0]  l4,
    output logic [31:0]  u1,
    output logic [31:0]  u2,
    output logic [31:0]  u3,
    output logic [31:0]  u4
);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  phase_reg, phase_next;
    logic        done_reg;
    logic        wr_en;

    logic [31:0] a_mem [4][4];
    logic [31:0] b_mem [4][4];
    logic [31:0] l_out [4];
    logic [31:0] u_out [4];

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign arr_rst  = (state_reg == CLEAR);
    assign done     = done_reg;
    assign wr_en    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            done_reg  <= (state_reg == DRAIN) && (phase_reg == 4'd3);
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    phase_next = '0;
                end
            end
            CLEAR: begin
                state_next = STREAM;
                phase_next = '0;
            end
            STREAM: begin
                if (phase_reg == 4'd6) begin
                    state_next = DRAIN;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            DRAIN: begin
                if (phase_reg == 4'd3) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    // A write landing on the start edge is visible to the first STREAM read,
    // since streams are only fetched after the CLEAR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    a_mem[i][k] <= '0;
                    b_mem[i][k] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (in_sel)
                    b_mem[in_row][k] <= in_data[32*k +: 32];
                else
                    a_mem[in_row][k] <= in_data[32*k +: 32];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [3:0]  offs;
            logic        in_win;
            logic [31:0] l_next, u_next;
            logic [31:0] l_lane_reg, u_lane_reg;

            // Lane gi is skewed by gi cycles; offs is the k index it reads.
            assign offs   = phase_next - 4'(gi);
            assign in_win = (state_next == STREAM) &&
                            (phase_next >= 4'(gi)) && (phase_next <= 4'(gi + 3));
            assign l_next = in_win ? a_mem[gi][offs[1:0]] : '0;
            assign u_next = in_win ? b_mem[offs[1:0]][gi] : '0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    l_lane_reg <= '0;
                    u_lane_reg <= '0;
                end else begin
                    l_lane_reg <= l_next;
                    u_lane_reg <= u_next;
                end
            end

            assign l_out[gi] = l_lane_reg;
            assign u_out[gi] = u_lane_reg;
        end
    endgenerate

    assign l1 = l_out[0];
    assign l2 = l_out[1];
    assign l3 = l_out[2];
    assign l4 = l_out[3];
    assign u1 = u_out[0];
    assign u2 = u_out[1];
    assign u3 = u_out[2];
    assign u4 = u_out[3];

endmodule
